mem_port_ctrl: RTL
==================

// Module: mem_port_ctrl
// PURPOSE
//  Parametrised dual-port memory controller; successor to the fixed 16-bit dual-port block.
//  Owns an inferred true-dual-port RAM and adds the following per port (A/B):
//   - req/ready handshake
//   - read-valid strobe
//   - configurable read latency
//   - range checking
//  Also provides a power-on clear sequencer and defined same-address collision rules.
//  Sits between the CPU datapath/IR logic and on-chip data memory.
// PARAMETERS
//  DATA_W  16     data word width
//  ADDR_W  16     address width per port
//  DEPTH   4096   words implemented (DEPTH <= 2**ADDR_W); higher addresses are out of range
//  RD_LAT  1      read latency in cycles, 1 or 2 (2 adds an output register stage)
// PORTS
//  clock     in   1       single clock, rising edge
//  reset_n   in   1       asynchronous, active-low reset
//  a_req     in   1       port A request; accepted when a_req & a_ready
//  a_we      in   1       1 = write, 0 = read (sampled with a_req)
//  a_addr    in   ADDR_W  port A word address
//  a_wdata   in   DATA_W  port A write data
//  a_ready   out  1       port A can accept (low during INIT)
//  a_rvalid  out  1       one-cycle strobe: a_rdata valid for an accepted read
//  a_rdata   out  DATA_W  port A read data, held until next a_rvalid
//  a_err     out  1       one-cycle strobe: accepted access was out of range
//  b_*       ...          identical set for port B
//  init_done out  1       high once the memory clear has completed
// BEHAVIOUR
//  Reset (reset_n low, async):
//   - *_ready, *_rvalid, *_err, init_done = 0; *_rdata = 0
//   - read pipeline flushed; FSM -> INIT; clear address counter = 0
//  FSM:
//   - INIT: writes 0 to word cnt via port A each cycle; cnt++.
//     At cnt == DEPTH-1, the next edge -> RUN.
//   - RUN: init_done = 1; a_ready = b_ready = 1. RUN is terminal until reset.
//   - INIT lasts exactly DEPTH cycles after reset release.
//   - Requests during INIT are ignored (not queued).
//  Accepted write (req & we & ready, addr < DEPTH):
//   - mem[addr] <= wdata at that edge
//   - no rvalid
//  Accepted read (req & ~we & ready, addr < DEPTH):
//   - rvalid pulses exactly RD_LAT cycles after the accepting edge, with rdata = mem[addr]
//   - back-to-back reads are sustained: one accept per port per cycle
//  Out of range (addr >= DEPTH):
//   - write dropped
//   - err pulses RD_LAT cycles after accept; for reads, rvalid also pulses with rdata = 0
//  Collisions, same cycle, same address:
//   - A write + B write: port A data wins; B write discarded (no error)
//   - write on one port + read on other: read returns OLD data (read-first);
//     the new data is visible to reads accepted on the next cycle
//   - A read + B read: both return the same word
//  Pipeline behaviour:
//   - rvalid/err never assert without a matching accepted read/access
//   - per-port results return in request order
//  Reset mid-operation:
//   - reads in flight are lost (no rvalid)
//   - memory re-cleared by INIT
// TESTING
//  1. Reset, DEPTH=16 -> a_ready = 0 for 16 cycles, then init_done = 1; reads of 0..15 all return 0x0000.
//  2. A write 0x00A5 -> 0xBEEF, then A read 0x00A5 -> a_rvalid exactly RD_LAT cycles later, a_rdata = 0xBEEF; test RD_LAT=1 and 2.
//  3. A write 0x10=0x1111 and B write 0x10=0x2222 in the same cycle -> later read of 0x10 = 0x1111.
//  4. mem[0x20]=0x0001; A write 0x20=0x0002 while B reads 0x20 in the same cycle -> b_rdata = 0x0001; B read next cycle -> 0x0002.
//  5. DEPTH=4096: A read 0x1000 -> a_err and a_rvalid pulse together, a_rdata = 0; A write 0x1000 leaves mem unchanged.
//  6. Issue 4 back-to-back B reads, pull reset_n low after the 2nd accept -> no b_rvalid after reset; INIT restarts, init_done = 0.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Dual-port memory controller: inferred true-dual-port RAM with per-port req/ready,
// read-valid strobe, 1- or 2-cycle read latency, range checking and a power-on clear.
module mem_port_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              init_done
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] cnt_r;
    logic             ready_r;
    logic             init_done_r;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]             req_s;
    logic [1:0]             we_s;
    logic [1:0][ADDR_W-1:0] addr_s;
    logic [1:0][DATA_W-1:0] wdata_s;
    logic [1:0]             in_rng_s;
    logic [1:0]             acc_s;
    logic [1:0]             rd_s;
    logic [1:0]             wr_s;
    logic [1:0][IDX_W-1:0]  idx_s;

    logic [1:0]             v1_r;
    logic [1:0]             e1_r;
    logic [1:0][DATA_W-1:0] d1_r;

    logic [1:0]             out_v_s;
    logic [1:0]             out_e_s;
    logic [1:0][DATA_W-1:0] out_d_s;

    assign req_s   = {b_req, a_req};
    assign we_s    = {b_we, a_we};
    assign addr_s  = {b_addr, a_addr};
    assign wdata_s = {b_wdata, a_wdata};

    // Per-port accept, range and command decode.
    always_comb begin
        in_rng_s = 2'b00;
        acc_s    = 2'b00;
        rd_s     = 2'b00;
        wr_s     = 2'b00;
        idx_s    = '0;
        for (int p = 0; p < 2; p++) begin
            in_rng_s[p] = ({1'b0, addr_s[p]} < DEPTH_C);
            acc_s[p]    = req_s[p] & ready_r;
            rd_s[p]     = acc_s[p] & ~we_s[p];
            wr_s[p]     = acc_s[p] & we_s[p] & in_rng_s[p];
            idx_s[p]    = addr_s[p][IDX_W-1:0];
        end
    end

    // Clear sequencer: walks every word once, then opens both ports for good.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == LAST_C) begin
                        state_r     <= ST_RUN;
                        ready_r     <= 1'b1;
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    ready_r     <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // RAM write: port A is applied last so it wins a same-address write collision.
    always_ff @(posedge clock) begin
        if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= '0;
        end else begin
            if (wr_s[1]) begin
                mem_r[idx_s[1]] <= wdata_s[1];
            end
            if (wr_s[0]) begin
                mem_r[idx_s[0]] <= wdata_s[0];
            end
        end
    end

    // First read stage: samples the pre-write word (read-first); out-of-range reads yield zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_r <= 2'b00;
            e1_r <= 2'b00;
            d1_r <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                v1_r[p] <= rd_s[p];
                e1_r[p] <= acc_s[p] & ~in_rng_s[p];
                if (rd_s[p]) begin
                    d1_r[p] <= in_rng_s[p] ? mem_r[idx_s[p]] : {DATA_W{1'b0}};
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [1:0]             v2_r;
            logic [1:0]             e2_r;
            logic [1:0][DATA_W-1:0] d2_r;

            // Extra output stage; data only moves with a valid so it holds between strobes.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    v2_r <= 2'b00;
                    e2_r <= 2'b00;
                    d2_r <= '0;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        v2_r[p] <= v1_r[p];
                        e2_r[p] <= e1_r[p];
                        if (v1_r[p]) begin
                            d2_r[p] <= d1_r[p];
                        end
                    end
                end
            end

            assign out_v_s = v2_r;
            assign out_e_s = e2_r;
            assign out_d_s = d2_r;
        end else begin : g_lat1
            assign out_v_s = v1_r;
            assign out_e_s = e1_r;
            assign out_d_s = d1_r;
        end
    endgenerate

    assign a_ready   = ready_r;
    assign b_ready   = ready_r;
    assign init_done = init_done_r;
    assign a_rvalid  = out_v_s[0];
    assign a_err     = out_e_s[0];
    assign a_rdata   = out_d_s[0];
    assign b_rvalid  = out_v_s[1];
    assign b_err     = out_e_s[1];
    assign b_rdata   = out_d_s[1];

endmodule
